// File: rtl/uibi_arb_pkg.sv
// Shared types and constants for the UIBI interconnect arbiter.
// Imported by the arbiter top and its round-robin picker.
package uibi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    TOUT = 2'b10,
    ERR  = 2'b11
  } arb_state_e;

  localparam int unsigned ERR_DATA = 32'd0;

  localparam logic [2:0] BUS_FULL = 3'b111;
  localparam logic [2:0] BUS_HALF = 3'b011;
  localparam logic [2:0] BUS_QUAR = 3'b001;
  localparam logic [2:0] BUS_NULL = 3'b000;

  // Index width for an n-entry array; never zero so single-entry arrays stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uibi_rr_picker.sv
// Round-robin picker: first requester after last_grant, wrapping modulo N.
// Purely combinational so any multi-master arbiter can reuse it.
module uibi_rr_picker
  import uibi_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant,
  output logic          valid
);

  logic [IW:0]   sum_s;
  logic [IW-1:0] idx_s;

  // Scan farthest-first so the closest requester after last_grant overwrites the rest.
  always_comb begin
    grant = '0;
    valid = |req;
    sum_s = '0;
    idx_s = '0;
    for (int i = N; i >= 1; i--) begin
      sum_s = {1'b0, last_grant} + (IW + 1)'(i);
      sum_s = (sum_s >= (IW + 1)'(N)) ? (sum_s - (IW + 1)'(N)) : sum_s;
      idx_s = IW'(sum_s);
      grant = req[idx_s] ? idx_s : grant;
    end
  end

endmodule

// File: rtl/uibi_arbiter.sv
// UIBI interconnect: round-robin master arbitration, bus_num slave decode,
// error response for unknown slaves and a watchdog for slaves that never answer.
module uibi_arbiter
  import uibi_arb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int SLAVE_WIDTH = 4,
  parameter int N_MASTERS   = 2,
  parameter int N_SLAVES    = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [N_MASTERS-1:0][XLEN-1:0]               master_dat_i,
  output logic [N_MASTERS-1:0][XLEN-1:0]               master_dat_o,
  input  logic [N_MASTERS-1:0][XLEN-SLAVE_WIDTH-1:0]   master_addr,
  input  logic [N_MASTERS-1:0][SLAVE_WIDTH-1:0]        master_num,
  input  logic [N_MASTERS-1:0]                         master_req,
  input  logic [N_MASTERS-1:0]                         master_wen,
  input  logic [N_MASTERS-1:0][2:0]                    master_mode,
  output logic [N_MASTERS-1:0]                         master_ready,
  output logic [N_SLAVES-1:0][XLEN-1:0]                slave_dat_o,
  input  logic [N_SLAVES-1:0][XLEN-1:0]                slave_dat_i,
  output logic [N_SLAVES-1:0][XLEN-SLAVE_WIDTH-1:0]    slave_addr,
  output logic [N_SLAVES-1:0]                          slave_req,
  output logic [N_SLAVES-1:0]                          slave_wen,
  output logic [N_SLAVES-1:0][2:0]                     slave_mode,
  input  logic [N_SLAVES-1:0]                          slave_ready,
  output logic                                         err_o
);

  localparam int MIW = idx_width(N_MASTERS);
  localparam int SIW = idx_width(N_SLAVES);
  localparam int CW  = $clog2(TIMEOUT + 1);

  arb_state_e     state_r, state_nxt_s;
  logic [MIW-1:0] grant_r, grant_nxt_s;
  logic [MIW-1:0] last_grant_r, last_grant_nxt_s;
  logic [SIW-1:0] num_r, num_nxt_s;
  logic [CW-1:0]  cnt_r, cnt_nxt_s;
  logic [MIW-1:0] pick_s;
  logic           pick_valid_s;
  logic           num_ok_s;

  uibi_rr_picker #(.N(N_MASTERS), .IW(MIW)) u_picker (
    .req        (master_req),
    .last_grant (last_grant_r),
    .grant      (pick_s),
    .valid      (pick_valid_s)
  );

  assign num_ok_s = (int'(master_num[pick_s]) < N_SLAVES);

  // Transaction state registers; an async reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      last_grant_r <= MIW'(N_MASTERS - 1);
      num_r        <= '0;
      cnt_r        <= '0;
    end else begin
      state_r      <= state_nxt_s;
      grant_r      <= grant_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      num_r        <= num_nxt_s;
      cnt_r        <= cnt_nxt_s;
    end
  end

  // Next-state: grant in IDLE, wait for the selected slave or the watchdog in BUSY.
  always_comb begin
    state_nxt_s      = state_r;
    grant_nxt_s      = grant_r;
    last_grant_nxt_s = last_grant_r;
    num_nxt_s        = num_r;
    cnt_nxt_s        = cnt_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          grant_nxt_s      = pick_s;
          last_grant_nxt_s = pick_s;
          num_nxt_s        = SIW'(master_num[pick_s]);
          cnt_nxt_s        = '0;
          state_nxt_s      = num_ok_s ? BUSY : ERR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        // A ready arriving on the last allowed cycle still completes normally.
        if (slave_ready[num_r]) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          state_nxt_s = TOUT;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      TOUT:    state_nxt_s = IDLE;
      ERR:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Bus routing: granted master broadcast to slaves, selected slave returned to it.
  always_comb begin
    slave_req    = '0;
    slave_addr   = '0;
    slave_dat_o  = '0;
    slave_wen    = '0;
    slave_mode   = '0;
    master_ready = '0;
    master_dat_o = '0;
    err_o        = 1'b0;
    case (state_r)
      BUSY: begin
        for (int s = 0; s < N_SLAVES; s++) begin
          slave_addr[s]  = master_addr[grant_r];
          slave_dat_o[s] = master_dat_i[grant_r];
          slave_wen[s]   = master_wen[grant_r];
          slave_mode[s]  = master_mode[grant_r];
        end
        slave_req[num_r]      = 1'b1;
        master_dat_o[grant_r] = slave_dat_i[num_r];
        master_ready[grant_r] = slave_ready[num_r];
      end
      TOUT, ERR: begin
        master_ready[grant_r] = 1'b1;
        master_dat_o[grant_r] = XLEN'(ERR_DATA);
        err_o                 = 1'b1;
      end
      default: begin
        err_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uibi_arbiter.sv
// Self-checking bench for uibi_arbiter: behavioural slaves with programmable
// latency, expected completions queued at stimulus time and popped on master_ready.
module tb_uibi_arbiter;
  import uibi_arb_pkg::*;

  localparam int XLEN = 32;
  localparam int SW   = 4;
  localparam int NM   = 2;
  localparam int NS   = 4;
  localparam int TMO  = 4;
  localparam int AW   = XLEN - SW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NM-1:0][XLEN-1:0] master_dat_i, master_dat_o;
  logic [NM-1:0][AW-1:0]   master_addr;
  logic [NM-1:0][SW-1:0]   master_num;
  logic [NM-1:0]           master_req, master_wen, master_ready;
  logic [NM-1:0][2:0]      master_mode;
  logic [NS-1:0][XLEN-1:0] slave_dat_o, slave_dat_i;
  logic [NS-1:0][AW-1:0]   slave_addr;
  logic [NS-1:0]           slave_req, slave_wen, slave_ready;
  logic [NS-1:0][2:0]      slave_mode;
  logic                    err_o;

  int lat [NS];
  int req_cyc [NS];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int              m;
    logic [XLEN-1:0] d;
    logic            e;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    bit              got;
    int              m;
    logic [XLEN-1:0] d;
    logic [XLEN-1:0] other_d;
    logic            e;
    int              cycles;
    int              req_cycles;
    logic [NS-1:0]   seen_req;
    bit              onehot_ok;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] wdat;
    logic            wen;
    logic [2:0]      mode;
  } obs_t;

  uibi_arbiter #(.XLEN(XLEN), .SLAVE_WIDTH(SW), .N_MASTERS(NM), .N_SLAVES(NS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .master_dat_i(master_dat_i), .master_dat_o(master_dat_o), .master_addr(master_addr),
    .master_num(master_num), .master_req(master_req), .master_wen(master_wen),
    .master_mode(master_mode), .master_ready(master_ready),
    .slave_dat_o(slave_dat_o), .slave_dat_i(slave_dat_i), .slave_addr(slave_addr),
    .slave_req(slave_req), .slave_wen(slave_wen), .slave_mode(slave_mode),
    .slave_ready(slave_ready), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Slave model: count cycles of req; ready in the cycle where count equals lat (-1 = never).
  always @(posedge clk) begin
    for (int s = 0; s < NS; s++) req_cyc[s] <= slave_req[s] ? req_cyc[s] + 1 : 0;
  end

  always_comb begin
    slave_ready = '0;
    for (int s = 0; s < NS; s++)
      slave_ready[s] = slave_req[s] && (lat[s] >= 0) && (req_cyc[s] == lat[s]);
  end

  function automatic logic [XLEN-1:0] sdat(input int s);
    return 32'hD00D_0000 + 32'(s) * 32'h0101_0101;
  endfunction

  task automatic drive(input int m, input logic [SW-1:0] num, input logic [AW-1:0] addr,
                       input logic wen, input logic [2:0] mode, input logic [XLEN-1:0] dat);
    master_num[m]   = num;
    master_addr[m]  = addr;
    master_wen[m]   = wen;
    master_mode[m]  = mode;
    master_dat_i[m] = dat;
    master_req[m]   = 1'b1;
  endtask

  // Observe negedges until some master_ready appears or the budget runs out.
  task automatic wait_ready(input int budget, output obs_t o);
    o.got = 1'b0; o.m = -1; o.d = '0; o.other_d = '0; o.e = 1'b0; o.cycles = 0;
    o.req_cycles = 0; o.seen_req = '0; o.onehot_ok = 1'b1;
    o.addr = '0; o.wdat = '0; o.wen = 1'b0; o.mode = 3'b000;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (slave_req != '0) begin
        if (o.req_cycles == 0) begin
          o.addr = slave_addr[0]; o.wdat = slave_dat_o[0];
          o.wen = slave_wen[0];   o.mode = slave_mode[0];
        end
        o.req_cycles++;
        o.seen_req |= slave_req;
        if (!$onehot(slave_req)) o.onehot_ok = 1'b0;
      end
      if (master_ready != '0) begin
        for (int k = NM - 1; k >= 0; k--) if (master_ready[k]) o.m = k;
        o.got = 1'b1;
        o.cycles = c;
        o.d = master_dat_o[o.m];
        o.other_d = master_dat_o[(o.m == 0) ? 1 : 0];
        o.e = err_o;
        if (!$onehot(master_ready)) o.onehot_ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    master_req = '0; master_wen = '0; master_mode = '0; master_num = '0;
    master_addr = '0; master_dat_i = '0;
    for (int s = 0; s < NS; s++) begin lat[s] = 0; slave_dat_i[s] = sdat(s); end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (slave_req !== 4'b0000) begin n_bad++; $display("FAIL reset_slave_req: got %b want 0000", slave_req); end
    n_cmp++; if (master_ready !== 2'b00) begin n_bad++; $display("FAIL reset_master_ready: got %b want 00", master_ready); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_o); end
    n_cmp++; if (master_dat_o !== '0) begin n_bad++; $display("FAIL reset_master_dat: got %h want 0", master_dat_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    obs_t o; exp_t x;
    exp_q.delete();
    lat[1] = 0; lat[3] = 0;
    @(negedge clk);
    drive(0, 4'd1, 28'h000_0020, 1'b0, BUS_FULL, 32'h0);
    drive(1, 4'd3, 28'h000_0030, 1'b0, BUS_FULL, 32'h0);
    for (int t = 0; t < 4; t++) exp_q.push_back('{m: t % 2, d: sdat((t % 2 == 0) ? 1 : 3), e: 1'b0});
    for (int t = 0; t < 4; t++) begin
      wait_ready(20, o);
      if (t == 3) master_req = '0;
      if (!o.got) begin
        n_cmp++; n_bad++; $display("FAIL rr_timeout: no master_ready for transaction %0d", t);
        master_req = '0;
        return;
      end
      x = exp_q.pop_front();
      n_cmp++;
      if (o.m !== x.m || o.d !== x.d || o.e !== x.e) begin
        n_bad++; $display("FAIL rr_grant[%0d]: got m=%0d d=%h e=%b want m=%0d d=%h e=%b", t, o.m, o.d, o.e, x.m, x.d, x.e);
      end
      n_cmp++;
      if (o.cycles !== ((t == 0) ? 1 : 2) || !o.onehot_ok) begin
        n_bad++; $display("FAIL rr_spacing[%0d]: got %0d cycles onehot=%b want %0d cycles onehot=1", t, o.cycles, o.onehot_ok, (t == 0) ? 1 : 2);
      end
    end
  endtask

  task automatic test_read_wait();
    obs_t o; exp_t x;
    exp_q.delete();
    lat[2] = 2;
    @(negedge clk);
    drive(0, 4'd2, 28'h000_0010, 1'b0, BUS_FULL, 32'h0);
    exp_q.push_back('{m: 0, d: sdat(2), e: 1'b0});
    wait_ready(20, o);
    master_req[0] = 1'b0;
    if (!o.got) begin n_cmp++; n_bad++; $display("FAIL read_timeout: no master_ready"); return; end
    x = exp_q.pop_front();
    n_cmp++; if (o.m !== x.m || o.d !== x.d || o.e !== x.e) begin
      n_bad++; $display("FAIL read_resp: got m=%0d d=%h e=%b want m=%0d d=%h e=%b", o.m, o.d, o.e, x.m, x.d, x.e); end
    n_cmp++; if (o.req_cycles !== 3 || o.seen_req !== 4'b0100) begin
      n_bad++; $display("FAIL read_slave_req: got %0d cycles on %b want 3 cycles on 0100", o.req_cycles, o.seen_req); end
    n_cmp++; if (o.addr !== 28'h000_0010 || o.other_d !== '0) begin
      n_bad++; $display("FAIL read_addr_other: got addr=%h other=%h want addr=0000010 other=0", o.addr, o.other_d); end
  endtask

  task automatic test_bad_num();
    obs_t o; exp_t x;
    exp_q.delete();
    @(negedge clk);
    drive(1, 4'd5, 28'h000_0044, 1'b0, BUS_FULL, 32'h0);
    exp_q.push_back('{m: 1, d: XLEN'(ERR_DATA), e: 1'b1});
    wait_ready(10, o);
    master_req[1] = 1'b0;
    if (!o.got) begin n_cmp++; n_bad++; $display("FAIL badnum_timeout: no master_ready"); return; end
    x = exp_q.pop_front();
    n_cmp++; if (o.m !== x.m || o.d !== x.d || o.e !== x.e) begin
      n_bad++; $display("FAIL badnum_resp: got m=%0d d=%h e=%b want m=%0d d=%h e=%b", o.m, o.d, o.e, x.m, x.d, x.e); end
    n_cmp++; if (o.cycles !== 1 || o.seen_req !== 4'b0000) begin
      n_bad++; $display("FAIL badnum_timing: got cycles=%0d req=%b want cycles=1 req=0000", o.cycles, o.seen_req); end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t x;
    exp_q.delete();
    lat[0] = -1;
    @(negedge clk);
    drive(0, 4'd0, 28'h000_0100, 1'b0, BUS_FULL, 32'h0);
    exp_q.push_back('{m: 0, d: XLEN'(ERR_DATA), e: 1'b1});
    wait_ready(20, o);
    master_req[0] = 1'b0;
    if (!o.got) begin n_cmp++; n_bad++; $display("FAIL tout_hang: no master_ready"); return; end
    x = exp_q.pop_front();
    n_cmp++; if (o.m !== x.m || o.d !== x.d || o.e !== x.e) begin
      n_bad++; $display("FAIL tout_resp: got m=%0d d=%h e=%b want m=%0d d=%h e=%b", o.m, o.d, o.e, x.m, x.d, x.e); end
    n_cmp++; if (o.req_cycles !== TMO || o.cycles !== TMO + 1) begin
      n_bad++; $display("FAIL tout_len: got req=%0d cycles=%0d want req=%0d cycles=%0d", o.req_cycles, o.cycles, TMO, TMO + 1); end
    // Ready on the last allowed BUSY cycle beats the watchdog.
    lat[0] = TMO - 1;
    @(negedge clk);
    drive(0, 4'd0, 28'h000_0104, 1'b0, BUS_FULL, 32'h0);
    exp_q.push_back('{m: 0, d: sdat(0), e: 1'b0});
    wait_ready(20, o);
    master_req[0] = 1'b0;
    if (!o.got) begin n_cmp++; n_bad++; $display("FAIL tout_edge_hang: no master_ready"); return; end
    x = exp_q.pop_front();
    n_cmp++; if (o.m !== x.m || o.d !== x.d || o.e !== x.e || o.req_cycles !== TMO) begin
      n_bad++; $display("FAIL tout_edge: got m=%0d d=%h e=%b req=%0d want m=%0d d=%h e=%b req=%0d", o.m, o.d, o.e, o.req_cycles, x.m, x.d, x.e, TMO); end
  endtask

  task automatic test_write();
    obs_t o; exp_t x;
    exp_q.delete();
    lat[3] = 1;
    @(negedge clk);
    drive(1, 4'd3, 28'hABC_DE66, 1'b1, BUS_QUAR, 32'h1234_5678);
    exp_q.push_back('{m: 1, d: sdat(3), e: 1'b0});
    wait_ready(20, o);
    master_req[1] = 1'b0;
    if (!o.got) begin n_cmp++; n_bad++; $display("FAIL write_timeout: no master_ready"); return; end
    x = exp_q.pop_front();
    n_cmp++; if (o.m !== x.m || o.d !== x.d || o.e !== x.e) begin
      n_bad++; $display("FAIL write_resp: got m=%0d d=%h e=%b want m=%0d d=%h e=%b", o.m, o.d, o.e, x.m, x.d, x.e); end
    n_cmp++; if (o.addr !== 28'hABC_DE66 || o.wdat !== 32'h1234_5678) begin
      n_bad++; $display("FAIL write_fwd: got addr=%h dat=%h want addr=abcde66 dat=12345678", o.addr, o.wdat); end
    n_cmp++; if (o.mode !== 3'b001 || o.wen !== 1'b1 || o.seen_req !== 4'b1000 || o.req_cycles !== 2) begin
      n_bad++; $display("FAIL write_ctrl: got mode=%b wen=%b req=%b n=%0d want mode=001 wen=1 req=1000 n=2", o.mode, o.wen, o.seen_req, o.req_cycles); end
  endtask

  task automatic test_reset_mid_busy();
    obs_t o; exp_t x;
    exp_q.delete();
    lat[2] = -1;
    @(negedge clk);
    drive(0, 4'd2, 28'h000_0200, 1'b0, BUS_FULL, 32'h0);
    repeat (2) @(negedge clk);
    n_cmp++; if (slave_req !== 4'b0100) begin n_bad++; $display("FAIL midrst_pre: got slave_req=%b want 0100", slave_req); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (slave_req !== 4'b0000 || master_ready !== 2'b00 || err_o !== 1'b0 || master_dat_o !== '0) begin
      n_bad++; $display("FAIL midrst_async: got req=%b rdy=%b err=%b dat=%h want all 0", slave_req, master_ready, err_o, master_dat_o); end
    master_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    lat[1] = 0; lat[2] = 0;
    drive(0, 4'd2, 28'h000_0204, 1'b0, BUS_FULL, 32'h0);
    drive(1, 4'd1, 28'h000_0208, 1'b0, BUS_FULL, 32'h0);
    exp_q.push_back('{m: 0, d: sdat(2), e: 1'b0});
    exp_q.push_back('{m: 1, d: sdat(1), e: 1'b0});
    for (int t = 0; t < 2; t++) begin
      wait_ready(20, o);
      master_req[t] = 1'b0;
      if (!o.got) begin n_cmp++; n_bad++; $display("FAIL midrst_hang: no master_ready %0d", t); master_req = '0; return; end
      x = exp_q.pop_front();
      n_cmp++; if (o.m !== x.m || o.d !== x.d || o.e !== x.e) begin
        n_bad++; $display("FAIL midrst_order[%0d]: got m=%0d d=%h e=%b want m=%0d d=%h e=%b", t, o.m, o.d, o.e, x.m, x.d, x.e); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read_wait();
    test_bad_num();
    test_timeout();
    test_write();
    test_reset_mid_busy();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uibi_arbiter.md
Name: uibi_arbiter

Overview:
- Shared interconnect between N UIBI masters and M UIBI slaves.
- Arbitrates master requests round-robin and decodes `bus_num` to a one-hot slave request.
- Forwards address, data, write enable and mode, and returns `ready` and read data to the granted master.
- Sits directly between the master-side and slave-side UIBI port arrays. It provides an error response for invalid slave numbers and a timeout watchdog for slaves that never respond.

Parameters:
- XLEN, 32, data width.
- SLAVE_WIDTH, 4, width of `bus_num`; address width is XLEN-SLAVE_WIDTH.
- N_MASTERS, 2, number of master ports (>=1).
- N_SLAVES, 4, number of implemented slaves (<=2**SLAVE_WIDTH).
- TIMEOUT, 255, maximum BUSY cycles without slave `ready` before the error response (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- master_dat_i  in  [N_MASTERS][XLEN]  write data from masters
- master_dat_o  out  [N_MASTERS][XLEN]  read data to masters
- master_addr  in  [N_MASTERS][XLEN-SLAVE_WIDTH]  address
- master_num  in  [N_MASTERS][SLAVE_WIDTH]  target slave number
- master_req  in  [N_MASTERS]  request
- master_wen  in  [N_MASTERS]  write enable
- master_mode  in  [N_MASTERS][3]  byte mode (111/011/001/000)
- master_ready  out  [N_MASTERS]  transaction done, 1-cycle pulse
- slave_dat_o  out  [N_SLAVES][XLEN]  write data to slaves
- slave_dat_i  in  [N_SLAVES][XLEN]  read data from slaves
- slave_addr  out  [N_SLAVES][XLEN-SLAVE_WIDTH]  address
- slave_req  out  [N_SLAVES]  request, at most one bit high
- slave_wen  out  [N_SLAVES]  write enable
- slave_mode  out  [N_SLAVES][3]  byte mode
- slave_ready  in  [N_SLAVES]  slave done
- err_o  out  1  1-cycle pulse on an invalid slave number or a timeout

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - state=IDLE, grant=0, last_grant=N_MASTERS-1, so master 0 wins first.
  - Timeout counter=0.
  - All `slave_req`, `master_ready` and `err_o` = 0; all `master_dat_o` = 0.
- Handshake:
  - A master holds `req`, addr, num, wen, mode and dat stable until it sees `ready`.
  - A slave pulses `ready` for one cycle; for reads, `slave_dat_i` is valid in that cycle.
- IDLE:
  - If any `master_req` is set, pick the first requester scanning from last_grant+1 modulo N_MASTERS (rr_picker).
  - Register grant and last_grant<=grant, clear the counter.
  - Go to BUSY if the latched num < N_SLAVES, else go to ERR.
  - No outputs are asserted in IDLE.
- BUSY:
  - Slave-side buses are broadcast to all slaves from the granted master: `slave_addr`, `slave_dat_o`, `slave_wen`, `slave_mode` (mode passed through unmodified).
  - `slave_req[num]` = 1; all other `slave_req` bits = 0.
  - `master_dat_o[grant]` = `slave_dat_i[num]` (combinational); non-granted masters see 0.
  - `master_ready[grant]` = `slave_ready[num]` (combinational).
  - On slave `ready`: go to IDLE.
  - Else, if counter==TIMEOUT-1: go to TOUT.
  - Else: counter++.
- TOUT (1 cycle):
  - `slave_req`=0, `master_ready[grant]`=1, `master_dat_o[grant]`=0, `err_o`=1.
  - Go to IDLE.
- ERR (1 cycle): identical outputs to TOUT, then go to IDLE.
- Latency:
  - A request seen at edge k puts `slave_req` high from cycle k+1.
  - Minimum 2 cycles from `req` to `ready` for a zero-wait slave.
  - One mandatory IDLE cycle between transactions, so a slave never sees `req` immediately after its `ready`.
- Simultaneous slave `ready` and timeout in the same cycle: `ready` wins, no `err_o`.
- Master dropping `req` mid-BUSY is a protocol violation. It is not aborted; the transaction completes by `ready` or timeout.
- `ready` from non-selected slaves is ignored.
- Async reset mid-BUSY: all outputs go to reset values immediately; the transaction is lost.
- N_MASTERS=1: rr_picker degenerates to grant=0.

Decomposition:
- Shared package `uibi_arb_pkg`:
  - State enum (IDLE, BUSY, TOUT, ERR).
  - ERR_DATA constant (0).
  - Bus mode constants `BUS_FULL`/`BUS_HALF`/`BUS_QUAR`/`BUS_NULL`.
- One sub-module `uibi_rr_picker`:
  - Combinational: req vector + last_grant -> next grant index + valid.
  - Reused by any future multi-master arbiter.

Test Plan:
- Master 0 reads slave 2, num=2, addr=0x10, slave ready 3 cycles after `req` -> `slave_req`=4'b0100 for 3 cycles, `master_ready[0]` pulses with `master_dat_o[0]`=slave data, `err_o`=0.
- Masters 0 and 1 both hold `req` to slaves 1 and 3 with zero-wait slaves -> grants in order 0,1,0,1, each transaction 2 cycles plus 1 IDLE, never starving master 1.
- Master 1 issues num=5 with N_SLAVES=4 -> ERR: `master_ready[1]`=1 and `err_o`=1 in cycle 2, no `slave_req` ever asserted.
- TIMEOUT=4, slave 0 never readies -> `slave_req[0]` high for exactly 4 cycles, then `master_ready`=1 with data 0 and `err_o`=1; slave `ready` in the 4th BUSY cycle -> normal completion, no `err_o`.
- Write with mode 3'b001, addr low bits 2'b10 -> `slave_mode`=3'b001, addr and `dat` forwarded bit-exact, `slave_wen`=1.
- Assert `rst_n` low mid-BUSY -> `slave_req`, `master_ready` and `err_o` go 0 asynchronously; after release with both masters requesting, master 0 is granted first.
